// File: rtl/id_scoreboard_if.sv
// ID-stage hazard scoreboard bundle: ID operand/destination info in, stall and forward selects out.
// master = pipeline control side driving ID info, slave = the scoreboard.
interface id_scoreboard_if #(
  parameter int AW    = 5,
  parameter int NRD   = 2,
  parameter int DEPTH = 3
) ();
  localparam int SW = $clog2(DEPTH + 1);

  logic                  id_valid;
  logic [NRD*AW-1:0]     id_src_addr;
  logic [NRD-1:0]        id_src_used;
  logic                  id_is_branch;
  logic [AW-1:0]         id_dst_addr;
  logic                  id_dst_we;
  logic                  id_dst_ld;
  logic                  flush;
  logic                  hold;
  logic                  stall;
  logic [NRD*SW-1:0]     fwd_sel;
  logic [15:0]           stall_cnt;

  modport master (
    output id_valid, id_src_addr, id_src_used, id_is_branch,
           id_dst_addr, id_dst_we, id_dst_ld, flush, hold,
    input  stall, fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_used, id_is_branch,
           id_dst_addr, id_dst_we, id_dst_ld, flush, hold,
    output stall, fwd_sel, stall_cnt
  );
endinterface

// File: rtl/id_scoreboard.sv
// Tracks in-flight register writers after ID; picks forward sources and stalls ID when a result is not yet forwardable.
// stall/fwd_sel are zero-latency (combinational); hold freezes all state.
module id_scoreboard #(
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int DEPTH   = 3,
  parameter int RDY_ALU = 1,
  parameter int RDY_LD  = 2
) (
  input  logic           clk,
  input  logic           reset,
  id_scoreboard_if.slave sb
);
  localparam int SW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] ld_q,  ld_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [15:0]      cnt_q, cnt_d;

  logic             stall_c;
  logic [NRD*SW-1:0] fwd_c;
  logic             load_e0;

  always_comb begin : lookup
    logic          not_rdy;
    logic          hit;
    logic          hit_ld;
    logic [SW-1:0] hit_k;
    logic [AW-1:0] src;
    int            eff;
    int            need;
    not_rdy = 1'b0;
    hit     = 1'b0;
    hit_ld  = 1'b0;
    hit_k   = '0;
    src     = '0;
    eff     = 0;
    need    = 0;
    fwd_c   = '0;
    for (int i = 0; i < NRD; i++) begin
      src    = sb.id_src_addr[i*AW +: AW];
      hit    = 1'b0;
      hit_ld = 1'b0;
      hit_k  = '0;
      // Scan oldest to youngest so the youngest matching writer is the last one kept.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (vld_q[k] && addr_q[k] == src) begin
          hit    = 1'b1;
          hit_k  = SW'(k);
          hit_ld = ld_q[k];
        end
      end
      if (sb.id_src_used[i] && src != '0 && hit) begin
        fwd_c[i*SW +: SW] = hit_k + SW'(1);
        eff  = int'(hit_k) + (sb.id_is_branch ? 0 : 1);
        need = hit_ld ? RDY_LD : RDY_ALU;
        if (eff < need) not_rdy = 1'b1;
      end
    end
    stall_c = sb.id_valid && !sb.flush && not_rdy;
  end

  assign load_e0 = sb.id_valid && sb.id_dst_we && (sb.id_dst_addr != '0) && !stall_c && !sb.flush;

  always_comb begin
    vld_d  = vld_q;
    ld_d   = ld_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (!sb.hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        vld_d[k]  = vld_q[k-1];
        ld_d[k]   = ld_q[k-1];
        addr_d[k] = addr_q[k-1];
      end
      // A stalled, flushed or non-writing ID instruction enters EX as a bubble.
      vld_d[0]  = load_e0;
      ld_d[0]   = sb.id_dst_ld;
      addr_d[0] = sb.id_dst_addr;
      if (stall_c && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) addr_q[k] <= '0;
    end else begin
      vld_q  <= vld_d;
      ld_q   <= ld_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sb.stall     = stall_c;
  assign sb.fwd_sel   = fwd_c;
  assign sb.stall_cnt = cnt_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed hazard scenarios then random traffic, all checked against an issue-time model.
module tb_id_scoreboard;
  localparam int AW = 5, NRD = 2, DEPTH = 3, RDY_ALU = 1, RDY_LD = 2;
  localparam int SW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_scoreboard_if #(.AW(AW), .NRD(NRD), .DEPTH(DEPTH)) sbi ();
  id_scoreboard #(.AW(AW), .NRD(NRD), .DEPTH(DEPTH), .RDY_ALU(RDY_ALU), .RDY_LD(RDY_LD))
    dut (.clk(clk), .reset(reset), .sb(sbi));

  int n_chk = 0;
  int n_pass = 0;

  // Model: every accepted writer is remembered with the advance count at which it left ID.
  int q_addr[$];
  int q_ld[$];
  int q_t[$];
  int adv = 0;
  int m_cnt = 0;
  logic exp_stall;
  logic [NRD*SW-1:0] exp_fwd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_eval();
    logic notready;
    notready = 1'b0;
    exp_fwd  = '0;
    for (int i = 0; i < NRD; i++) begin
      int src, f, st;
      src = int'(sbi.id_src_addr[i*AW +: AW]);
      f = -1;
      foreach (q_t[j]) begin
        st = adv - q_t[j] - 1;
        if (st < DEPTH && q_addr[j] == src) f = j;
      end
      if (sbi.id_src_used[i] && src != 0 && f >= 0) begin
        st = adv - q_t[f] - 1;
        exp_fwd[i*SW +: SW] = SW'(st + 1);
        if (st + (sbi.id_is_branch ? 0 : 1) < (q_ld[f] != 0 ? RDY_LD : RDY_ALU)) notready = 1'b1;
      end
    end
    exp_stall = sbi.id_valid && !sbi.flush && notready;
  endtask

  task automatic model_reset();
    q_addr.delete(); q_ld.delete(); q_t.delete();
    adv = 0;
    m_cnt = 0;
  endtask

  task automatic apply(input logic v, input int s0, input int s1, input logic [1:0] used,
                       input logic br, input int d, input logic we, input logic ld,
                       input logic fl, input logic hd);
    sbi.id_valid     = v;
    sbi.id_src_addr  = {AW'(s1), AW'(s0)};
    sbi.id_src_used  = used;
    sbi.id_is_branch = br;
    sbi.id_dst_addr  = AW'(d);
    sbi.id_dst_we    = we;
    sbi.id_dst_ld    = ld;
    sbi.flush        = fl;
    sbi.hold         = hd;
    @(negedge clk);
    model_eval();
    chk("stall", 32'(sbi.stall), 32'(exp_stall));
    chk("fwd_sel", 32'(sbi.fwd_sel), 32'(exp_fwd));
    chk("stall_cnt", 32'(sbi.stall_cnt), 32'(m_cnt));
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset && !sbi.hold) begin
      if (sbi.id_valid && sbi.id_dst_we && sbi.id_dst_addr != '0 && !exp_stall && !sbi.flush) begin
        q_addr.push_back(int'(sbi.id_dst_addr));
        q_ld.push_back(int'(sbi.id_dst_ld));
        q_t.push_back(adv);
      end
      if (exp_stall && m_cnt != 65535) m_cnt++;
      adv++;
      while (q_t.size() > 0 && adv - q_t[0] - 1 >= DEPTH) begin
        void'(q_t.pop_front()); void'(q_addr.pop_front()); void'(q_ld.pop_front());
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      apply(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      advance();
    end
  endtask

  initial begin
    sbi.id_valid = 1'b1; sbi.id_src_addr = {AW'(3), AW'(3)}; sbi.id_src_used = 2'b11;
    sbi.id_is_branch = 1'b1; sbi.id_dst_addr = AW'(3); sbi.id_dst_we = 1'b1;
    sbi.id_dst_ld = 1'b1; sbi.flush = 1'b0; sbi.hold = 1'b0;
    #12;
    chk("rst_stall", 32'(sbi.stall), 32'd0);
    chk("rst_fwd", 32'(sbi.fwd_sel), 32'd0);
    chk("rst_cnt", 32'(sbi.stall_cnt), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    idle(1);

    // lw $8 ; add uses $8
    apply(1, 0, 0, 2'b00, 0, 8, 1, 1, 0, 0); advance();
    apply(1, 8, 0, 2'b01, 0, 11, 1, 0, 0, 0);
    chk("lw_add_stall1", 32'(sbi.stall), 32'd1);
    chk("lw_add_fwd1", 32'(sbi.fwd_sel[SW-1:0]), 32'd1);
    advance();
    apply(1, 8, 0, 2'b01, 0, 11, 1, 0, 0, 0);
    chk("lw_add_stall2", 32'(sbi.stall), 32'd0);
    chk("lw_add_fwd2", 32'(sbi.fwd_sel[SW-1:0]), 32'd2);
    chk("lw_add_cnt", 32'(sbi.stall_cnt), 32'd1);
    advance(); idle(3);

    // add $9 ; beq $9
    apply(1, 0, 0, 2'b00, 0, 9, 1, 0, 0, 0); advance();
    apply(1, 9, 0, 2'b01, 1, 0, 0, 0, 0, 0);
    chk("add_beq_stall1", 32'(sbi.stall), 32'd1);
    advance();
    apply(1, 9, 0, 2'b01, 1, 0, 0, 0, 0, 0);
    chk("add_beq_stall2", 32'(sbi.stall), 32'd0);
    chk("add_beq_fwd", 32'(sbi.fwd_sel[SW-1:0]), 32'd2);
    advance(); idle(3);

    // lw $10 ; beq $10: two stall cycles, cumulative count 2 + 2
    apply(1, 0, 0, 2'b00, 0, 10, 1, 1, 0, 0); advance();
    for (int c = 0; c < 2; c++) begin
      apply(1, 0, 10, 2'b10, 1, 0, 0, 0, 0, 0);
      chk("lw_beq_stall", 32'(sbi.stall), 32'd1);
      advance();
    end
    apply(1, 0, 10, 2'b10, 1, 0, 0, 0, 0, 0);
    chk("lw_beq_release", 32'(sbi.stall), 32'd0);
    chk("lw_beq_fwd", 32'(sbi.fwd_sel[2*SW-1:SW]), 32'd3);
    chk("lw_beq_cnt", 32'(sbi.stall_cnt), 32'd4);
    advance(); idle(3);

    // $0 writer and unused source never create hazards
    apply(1, 0, 0, 2'b00, 0, 0, 1, 1, 0, 0); advance();
    apply(1, 0, 0, 2'b11, 1, 0, 0, 0, 0, 0);
    chk("r0_stall", 32'(sbi.stall), 32'd0);
    chk("r0_fwd", 32'(sbi.fwd_sel), 32'd0);
    advance();
    apply(1, 0, 0, 2'b00, 0, 12, 1, 1, 0, 0); advance();
    apply(1, 12, 12, 2'b00, 1, 0, 0, 0, 0, 0);
    chk("unused_stall", 32'(sbi.stall), 32'd0);
    chk("unused_fwd", 32'(sbi.fwd_sel), 32'd0);
    advance(); idle(3);

    // load $5 then ALU $5: youngest wins; hold freezes a stalled branch
    apply(1, 0, 0, 2'b00, 0, 5, 1, 1, 0, 0); advance();
    apply(1, 0, 0, 2'b00, 0, 5, 1, 0, 0, 0); advance();
    for (int c = 0; c < 3; c++) begin
      apply(1, 5, 0, 2'b01, 1, 0, 0, 0, 0, 1);
      chk("hold_stall", 32'(sbi.stall), 32'd1);
      chk("hold_fwd", 32'(sbi.fwd_sel[SW-1:0]), 32'd1);
      advance();
    end
    apply(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    chk("youngest_stall", 32'(sbi.stall), 32'd0);
    chk("youngest_fwd", 32'(sbi.fwd_sel[SW-1:0]), 32'd1);
    advance(); idle(3);

    // reset in the second cycle of a load-branch stall
    apply(1, 0, 0, 2'b00, 0, 10, 1, 1, 0, 0); advance();
    apply(1, 10, 0, 2'b01, 1, 0, 0, 0, 0, 0); advance();
    apply(1, 10, 0, 2'b01, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_stall", 32'(sbi.stall), 32'd1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_stall", 32'(sbi.stall), 32'd0);
    chk("async_rst_cnt", 32'(sbi.stall_cnt), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    apply(1, 10, 0, 2'b01, 1, 0, 0, 0, 0, 0);
    chk("post_rst_stall", 32'(sbi.stall), 32'd0);
    advance();

    for (int c = 0; c < 600; c++) begin
      apply(($urandom % 8) != 0, int'($urandom % 8), int'($urandom % 8), 2'($urandom),
            ($urandom % 4) == 0, int'($urandom % 8), ($urandom % 4) != 0, ($urandom % 3) == 0,
            ($urandom % 10) == 0, ($urandom % 8) == 0);
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
